// File: rtl/msu_msg_sched.sv
// MSU-1 HPS mailbox scheduler: one outstanding 48-bit message, four queued request classes.
// Timeout/retry logic and timeout_err are built only when MSU_SCHED_RETRY_EN is defined.
module msu_msg_sched #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd2_000_000,
  parameter int          MAX_RETRY   = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        track_req,
  input  logic [15:0] track_num,
  input  logic        jump_req,
  input  logic [31:0] jump_sector,
  input  logic        sector_req,
  input  logic        msg_taken,
  output logic [47:0] msg_out,
  output logic        msg_toggle,
  output logic        busy,
  output logic [3:0]  pending,
  output logic        timeout_err
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state_r;
  logic        track_old_r;
  logic        jump_old_r;
  logic        sector_old_r;
  logic [3:0]  pend_r;          // {reset, track, jump, sector}
  logic [15:0] track_pay_r;
  logic [31:0] jump_pay_r;
  logic        out_track_r;     // outstanding message is a track mount
  logic [47:0] msg_r;
  logic        tog_r;

  logic        track_edge_s;
  logic        jump_edge_s;
  logic        sector_edge_s;
  logic        sector_ok_s;
  logic [3:0]  sel_s;
  logic [3:0]  pend_next_s;
  logic [47:0] issue_msg_s;

  assign track_edge_s  = track_req  & ~track_old_r;
  assign jump_edge_s   = jump_req   & ~jump_old_r;
  assign sector_edge_s = sector_req & ~sector_old_r;

  // A sector request is pointless while a track mount is queued or in flight.
  assign sector_ok_s = sector_edge_s & ~jump_edge_s & ~pend_r[2]
                     & ~((state_r == S_WAIT) & out_track_r);

  // Priority select of the class to issue this cycle.
  always_comb begin
    sel_s = 4'b0000;
    if (state_r == S_IDLE) begin
      if (pend_r[3])      sel_s = 4'b1000;
      else if (pend_r[2]) sel_s = 4'b0100;
      else if (pend_r[1]) sel_s = 4'b0010;
      else if (pend_r[0]) sel_s = 4'b0001;
      else                sel_s = 4'b0000;
    end else begin
      sel_s = 4'b0000;
    end
  end

  // Issue clears first, new edges set afterwards so a same-cycle request stays queued.
  assign pend_next_s[3] = pend_r[3] & ~sel_s[3];
  assign pend_next_s[2] = (pend_r[2] & ~sel_s[2]) | track_edge_s;
  assign pend_next_s[1] = ((pend_r[1] & ~sel_s[1]) | jump_edge_s) & ~track_edge_s;
  assign pend_next_s[0] = ((pend_r[0] & ~sel_s[0]) | sector_ok_s) & ~track_edge_s & ~jump_edge_s;

  // Message word for the selected class, built from the payload captured before this edge.
  always_comb begin
    issue_msg_s = msg_r;
    case (sel_s)
      4'b1000: issue_msg_s = 48'h0000_0000_00FF;
      4'b0100: issue_msg_s = {16'h0000, track_pay_r, 16'h0035};
      4'b0010: issue_msg_s = {jump_pay_r, 16'h0036};
      4'b0001: issue_msg_s = 48'h0000_0000_0034;
      default: issue_msg_s = msg_r;
    endcase
  end

`ifdef MSU_SCHED_RETRY_EN
  logic [23:0] timer_r;
  logic [1:0]  retry_r;
  logic        err_r;
`endif

  // Request capture, queue update and the IDLE/WAIT mailbox FSM.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r      <= S_IDLE;
      track_old_r  <= 1'b0;
      jump_old_r   <= 1'b0;
      sector_old_r <= 1'b0;
      pend_r       <= 4'b1000;
      track_pay_r  <= 16'h0000;
      jump_pay_r   <= 32'h0000_0000;
      out_track_r  <= 1'b0;
      msg_r        <= 48'h0000_0000_0000;
      tog_r        <= 1'b0;
`ifdef MSU_SCHED_RETRY_EN
      timer_r      <= 24'd0;
      retry_r      <= 2'd0;
      err_r        <= 1'b0;
`endif
    end else begin
      track_old_r  <= track_req;
      jump_old_r   <= jump_req;
      sector_old_r <= sector_req;
      pend_r       <= pend_next_s;
      if (track_edge_s) track_pay_r <= track_num;
      if (jump_edge_s)  jump_pay_r  <= jump_sector;
      case (state_r)
        S_IDLE: begin
          if (|sel_s) begin
            msg_r       <= issue_msg_s;
            tog_r       <= ~tog_r;
            out_track_r <= sel_s[2];
            state_r     <= S_WAIT;
`ifdef MSU_SCHED_RETRY_EN
            timer_r     <= 24'd0;
            retry_r     <= 2'd0;
`endif
          end
        end
        S_WAIT: begin
          if (msg_taken) begin
            state_r <= S_IDLE;
          end
`ifdef MSU_SCHED_RETRY_EN
          else if (timer_r == TIMEOUT_CYC - 24'd1) begin
            if (retry_r < 2'(MAX_RETRY)) begin
              tog_r   <= ~tog_r;
              timer_r <= 24'd0;
              retry_r <= retry_r + 2'd1;
            end else begin
              err_r   <= 1'b1;
              state_r <= S_IDLE;
            end
          end else if (timer_r != 24'hFF_FFFF) begin
            timer_r <= timer_r + 24'd1;
          end
`endif
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign msg_out    = msg_r;
  assign msg_toggle = tog_r;
  assign busy       = (state_r == S_WAIT);
  assign pending    = pend_r;

`ifdef MSU_SCHED_RETRY_EN
  assign timeout_err = err_r;
`else
  logic unused_cfg;
  assign unused_cfg  = (^TIMEOUT_CYC) ^ (MAX_RETRY != 0);
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_msu_msg_sched.sv
// Self-checking bench for msu_msg_sched: directed scenarios plus randomized traffic
// compared every cycle against an event-level mailbox model.
module tb_msu_msg_sched;

`ifdef MSU_SCHED_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  localparam int T_CYC = 8;
  localparam int M_RET = 2;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        track_req = 1'b0;
  logic [15:0] track_num = 16'h0000;
  logic        jump_req = 1'b0;
  logic [31:0] jump_sector = 32'h0;
  logic        sector_req = 1'b0;
  logic        msg_taken = 1'b0;
  logic [47:0] msg_out;
  logic        msg_toggle;
  logic        busy;
  logic [3:0]  pending;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk_sys = ~clk_sys;

  msu_msg_sched #(.TIMEOUT_CYC(24'd8), .MAX_RETRY(2)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .track_req(track_req), .track_num(track_num),
    .jump_req(jump_req), .jump_sector(jump_sector),
    .sector_req(sector_req), .msg_taken(msg_taken),
    .msg_out(msg_out), .msg_toggle(msg_toggle), .busy(busy),
    .pending(pending), .timeout_err(timeout_err)
  );

  // Reference model: a queue of request flags per class plus one outstanding-message record.
  logic [3:0]  m_pend = 4'b1000;   // index 3 reset, 2 track, 1 jump, 0 sector
  logic [15:0] m_trk = 16'h0;
  logic [31:0] m_jmp = 32'h0;
  bit          m_old_t, m_old_j, m_old_s;
  bit          m_out;
  int          m_cls;
  int          m_age;
  int          m_tries;
  logic [47:0] m_msg = 48'h0;
  bit          m_tog, m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [47:0] fmt(input int cls);
    case (cls)
      3:       return 48'h0000_0000_00FF;
      2:       return {16'h0000, m_trk, 16'h0035};
      1:       return {m_jmp, 16'h0036};
      default: return 48'h0000_0000_0034;
    endcase
  endfunction

  task automatic model_step();
    bit et, ej, es, sec_ok;
    int pick;
    if (reset) begin
      m_pend = 4'b1000; m_msg = 48'h0; m_tog = 0; m_err = 0; m_out = 0;
      m_old_t = 0; m_old_j = 0; m_old_s = 0;
    end else begin
      et = track_req && !m_old_t;
      ej = jump_req && !m_old_j;
      es = sector_req && !m_old_s;
      sec_ok = es && !ej && !m_pend[2] && !(m_out && m_cls == 2);
      if (!m_out) begin
        pick = -1;
        for (int c = 3; c >= 0; c--) if (m_pend[c] && pick < 0) pick = c;
        if (pick >= 0) begin
          m_msg = fmt(pick); m_tog = !m_tog; m_pend[pick] = 1'b0;
          m_out = 1; m_cls = pick; m_age = 0; m_tries = 0;
        end
      end else if (msg_taken) begin
        m_out = 0;
      end else if (RETRY) begin
        m_age++;
        if (m_age == T_CYC) begin
          if (m_tries < M_RET) begin
            m_tog = !m_tog; m_age = 0; m_tries++;
          end else begin
            m_err = 1; m_out = 0;
          end
        end
      end
      if (et) begin
        m_pend[2] = 1'b1; m_pend[1] = 1'b0; m_pend[0] = 1'b0; m_trk = track_num;
      end
      if (ej) begin
        m_jmp = jump_sector; m_pend[0] = 1'b0;
        if (!et) m_pend[1] = 1'b1;
      end
      if (sec_ok && !et) m_pend[0] = 1'b1;
      m_old_t = track_req; m_old_j = jump_req; m_old_s = sector_req;
    end
  endtask

  task automatic compare_all();
    check("msg_out", 64'(msg_out), 64'(m_msg));
    check("msg_toggle", 64'(msg_toggle), 64'(m_tog));
    check("busy", 64'(busy), 64'(m_out));
    check("pending", 64'(pending), 64'(m_pend));
    check("timeout_err", 64'(timeout_err), 64'(m_err));
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    // Reset release
    reset = 1'b1;
    repeat (3) tick();
    check("rst_pending", 64'(pending), 64'(4'b1000));
    reset = 1'b0;
    tick();
    check("rel_msg", 64'(msg_out), 64'h0000_0000_00FF);
    check("rel_tog", 64'(msg_toggle), 64'd1);
    check("rel_pend", 64'(pending), 64'd0);
    check("rel_busy", 64'(busy), 64'd1);

    // Track mount
    msg_taken = 1'b1; tick(); msg_taken = 1'b0;
    track_req = 1'b1; track_num = 16'h0012; tick();
    check("trk_pend", 64'(pending), 64'(4'b0100));
    tick();
    check("trk_msg", 64'(msg_out), 64'h0000_0012_0035);
    check("trk_tog", 64'(msg_toggle), 64'd0);
    sector_req = 1'b1; tick();
    check("sec_supp", 64'(pending), 64'd0);

    // Queued priority
    sector_req = 1'b0; jump_req = 1'b1; jump_sector = 32'h0000_1000; tick();
    sector_req = 1'b1; tick();
    check("q_pend", 64'(pending), 64'(4'b0010));
    msg_taken = 1'b1; tick(); msg_taken = 1'b0; tick();
    check("q_msg", 64'(msg_out), 64'h0000_1000_0036);

    // Cancellation
    track_req = 1'b0; jump_req = 1'b0; sector_req = 1'b0; tick();
    jump_req = 1'b1; jump_sector = 32'h2; sector_req = 1'b1; tick();
    check("cx_pend1", 64'(pending), 64'(4'b0010));
    track_req = 1'b1; track_num = 16'h0005; tick();
    check("cx_pend2", 64'(pending), 64'(4'b0100));
    msg_taken = 1'b1; tick(); msg_taken = 1'b0; tick();
    check("cx_msg", 64'(msg_out), 64'h0000_0005_0035);

    // Timeout / retry
    msg_taken = 1'b1; track_req = 1'b0; jump_req = 1'b0; sector_req = 1'b0; tick();
    msg_taken = 1'b0; tick();
    sector_req = 1'b1; tick(); tick();
    check("to_msg", 64'(msg_out), 64'h0000_0000_0034);
    check("to_tog0", 64'(msg_toggle), 64'd1);
    if (RETRY) begin
      for (int k = 1; k <= 24; k++) begin
        tick();
        check("to_tog", 64'(msg_toggle), 64'(1'b1 ^ (k >= 8) ^ (k >= 16)));
        check("to_err", 64'(timeout_err), 64'(k >= 24));
      end
      check("to_busy", 64'(busy), 64'd0);
    end else begin
      repeat (40) tick();
      check("nort_busy", 64'(busy), 64'd1);
      check("nort_err", 64'(timeout_err), 64'd0);
    end

    // Reset mid-WAIT with jump and sector queued
    sector_req = 1'b0; tick();
    jump_req = 1'b1; jump_sector = 32'h7; tick(); tick();
    jump_req = 1'b0; tick();
    jump_req = 1'b1; tick();
    sector_req = 1'b1; tick();
    check("mw_pend", 64'(pending), 64'(4'b0011));
    check("mw_busy", 64'(busy), 64'd1);
    reset = 1'b1; tick();
    check("mw_rst_pend", 64'(pending), 64'(4'b1000));
    check("mw_rst_err", 64'(timeout_err), 64'd0);
    reset = 1'b0; tick();
    check("mw_rel_msg", 64'(msg_out), 64'h0000_0000_00FF);
    check("mw_rel_tog", 64'(msg_toggle), 64'd1);

    // Randomized traffic: at most one request line toggles per cycle
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) track_req = ~track_req;
      if (r == 1) jump_req = ~jump_req;
      if (r == 2) sector_req = ~sector_req;
      track_num   = 16'($urandom);
      jump_sector = $urandom;
      msg_taken   = (i < 2000) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 11) == 0);
      reset       = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
